// File: rtl/param_countdown_timer_if.sv
// Control/status bundle between the traffic-light FSM (master) and the countdown timer (slave).
// Optional TIMER_AUTORELOAD_EN adds the auto_reload request line.
interface param_countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             tick_en;
  logic [WIDTH-1:0] Value;
  logic             start_timer;
  logic             pause;
  logic             clear;
  logic             busy;
  logic [WIDTH-1:0] time_left;
  logic             expired;
  logic             expired_pulse;
`ifdef TIMER_AUTORELOAD_EN
  logic             auto_reload;

  modport master (
    output tick_en, Value, start_timer, pause, clear, auto_reload,
    input  busy, time_left, expired, expired_pulse
  );
  modport slave (
    input  tick_en, Value, start_timer, pause, clear, auto_reload,
    output busy, time_left, expired, expired_pulse
  );
`else
  modport master (
    output tick_en, Value, start_timer, pause, clear,
    input  busy, time_left, expired, expired_pulse
  );
  modport slave (
    input  tick_en, Value, start_timer, pause, clear,
    output busy, time_left, expired, expired_pulse
  );
`endif
endinterface

// File: rtl/param_countdown_timer.sv
// One-shot countdown timer clocked by tick_en strobes through a TICK_DIV prescaler.
// Define TIMER_AUTORELOAD_EN to enable periodic reload on expiry via auto_reload.
module param_countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  param_countdown_timer_if.slave tif
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] time_left_q, time_left_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             expired_q, expired_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             auto_reload;

`ifdef TIMER_AUTORELOAD_EN
  assign auto_reload = tif.auto_reload;
`else
  assign auto_reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      time_left_q <= '0;
      presc_q     <= '0;
      expired_q   <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      presc_q     <= presc_d;
      expired_q   <= expired_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    presc_d     = presc_q;
    expired_d   = expired_q;
    pulse_d     = 1'b0;
    if (tif.clear) begin
      state_d     = S_IDLE;
      time_left_d = '0;
      presc_d     = '0;
      expired_d   = 1'b0;
    end else if (tif.start_timer) begin
      presc_d   = '0;
      expired_d = 1'b0;
      if (tif.Value == '0) begin
        state_d     = S_EXPIRED;
        time_left_d = '0;
        expired_d   = 1'b1;
        pulse_d     = 1'b1;
      end else begin
        state_d     = S_RUN;
        time_left_d = tif.Value;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (tif.pause) begin
            state_d = S_PAUSE;
          end else if (tif.tick_en) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              // The <=1 test also keeps time_left from ever wrapping below zero.
              if (time_left_q <= WIDTH'(1)) begin
                pulse_d = 1'b1;
                if (auto_reload && (tif.Value != '0)) begin
                  time_left_d = tif.Value;
                end else begin
                  state_d     = S_EXPIRED;
                  time_left_d = '0;
                  expired_d   = 1'b1;
                end
              end else begin
                time_left_d = time_left_q - WIDTH'(1);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        S_PAUSE: begin
          // Ticks arriving while paused are dropped; the prescaler phase is kept.
          if (!tif.pause) state_d = S_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  assign tif.busy          = busy_q;
  assign tif.time_left     = time_left_q;
  assign tif.expired       = expired_q;
  assign tif.expired_pulse = pulse_q;

endmodule

// File: tb/tb_param_countdown_timer.sv
// Scoreboard bench: two timers (TICK_DIV=1 and 4) share stimulus; a tick-count model predicts outputs.
module tb_param_countdown_timer;

  typedef struct {
    bit busy;
    int tl;
    bit exp;
    bit pulse;
  } exp_t;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  param_countdown_timer_if #(.WIDTH(4)) if1 ();
  param_countdown_timer_if #(.WIDTH(4)) if4 ();

  param_countdown_timer #(.WIDTH(4), .TICK_DIV(1)) u_dut1 (.clk(clk), .Reset_n(Reset_n), .tif(if1.slave));
  param_countdown_timer #(.WIDTH(4), .TICK_DIV(4)) u_dut4 (.clk(clk), .Reset_n(Reset_n), .tif(if4.slave));

  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model: remaining qualifying ticks until expiry, per DUT.
  int divs[2] = '{1, 4};
  bit m_active[2];
  bit m_paused[2];
  bit m_exp[2];
  bit m_pulse[2];
  int m_ticks[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0; m_paused[d] = 0; m_exp[d] = 0; m_pulse[d] = 0; m_ticks[d] = 0;
    end
  endfunction

  function automatic void model_step(int d, bit st, int v, bit pa, bit cl, bit tk, bit ar);
    m_pulse[d] = 0;
    if (cl) begin
      m_active[d] = 0; m_paused[d] = 0; m_exp[d] = 0; m_ticks[d] = 0;
    end else if (st) begin
      m_exp[d] = 0; m_paused[d] = 0;
      if (v == 0) begin
        m_active[d] = 0; m_exp[d] = 1; m_pulse[d] = 1; m_ticks[d] = 0;
      end else begin
        m_active[d] = 1; m_ticks[d] = v * divs[d];
      end
    end else if (m_active[d] && !m_paused[d]) begin
      if (pa) m_paused[d] = 1;
      else if (tk) begin
        m_ticks[d]--;
        if (m_ticks[d] == 0) begin
          m_pulse[d] = 1;
          if (ar && v != 0) m_ticks[d] = v * divs[d];
          else begin
            m_active[d] = 0; m_exp[d] = 1;
          end
        end
      end
    end else if (m_active[d] && m_paused[d]) begin
      if (!pa) m_paused[d] = 0;
    end
  endfunction

  function automatic exp_t model_out(int d);
    exp_t e;
    e.busy  = m_active[d];
    e.tl    = (m_ticks[d] + divs[d] - 1) / divs[d];
    e.exp   = m_exp[d];
    e.pulse = m_pulse[d];
    return e;
  endfunction

  task automatic compare(input string name, input int d, input exp_t e);
    bit b, x, p;
    int t;
    if (d == 0) begin
      b = if1.busy; t = int'(if1.time_left); x = if1.expired; p = if1.expired_pulse;
    end else begin
      b = if4.busy; t = int'(if4.time_left); x = if4.expired; p = if4.expired_pulse;
    end
    vectors++;
    if (b !== e.busy || t != e.tl || x !== e.exp || p !== e.pulse) begin
      miscompares++;
      $display("FAIL %s div%0d t=%0t: got busy=%0d tl=%0d exp=%0d pulse=%0d, required busy=%0d tl=%0d exp=%0d pulse=%0d",
               name, divs[d], $time, b, t, x, p, e.busy, e.tl, e.exp, e.pulse);
    end
  endtask

  task automatic drive(input bit st, input int v, input bit pa, input bit cl, input bit tk, input bit ar);
    if1.start_timer = st; if1.Value = 4'(v); if1.pause = pa; if1.clear = cl; if1.tick_en = tk;
    if4.start_timer = st; if4.Value = 4'(v); if4.pause = pa; if4.clear = cl; if4.tick_en = tk;
`ifdef TIMER_AUTORELOAD_EN
    if1.auto_reload = ar; if4.auto_reload = ar;
`endif
  endtask

  task automatic step(input bit st, input int v, input bit pa, input bit cl, input bit tk, input bit ar);
    @(negedge clk);
    drive(st, v, pa, cl, tk, ar);
    model_step(0, st, v, pa, cl, tk, ar);
    model_step(1, st, v, pa, cl, tk, ar);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  task automatic check_reset(input string name);
    exp_t z;
    z.busy = 0; z.tl = 0; z.exp = 0; z.pulse = 0;
    compare(name, 0, z);
    compare(name, 1, z);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_reset("async_reset");
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  // Monitor: timer presents a full output word every clock; compare it against the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) compare("sb", 0, q0.pop_front());
      if (q1.size() > 0) compare("sb", 1, q1.pop_front());
    end
  end

  initial begin
    bit ar_en;
`ifdef TIMER_AUTORELOAD_EN
    ar_en = 1;
`else
    ar_en = 0;
`endif
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    Reset_n = 1'b1;

    // Idle: ticks and pause do nothing.
    step(0, 7, 0, 0, 1, 0); step(0, 7, 1, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
    // Value=3 runs down.
    step(1, 3, 0, 0, 0, 0);
    repeat (3) step(0, 3, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    // Value=0 expires immediately.
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0);
    // Pause midway; paused ticks dropped.
    step(1, 2, 0, 0, 0, 0);
    repeat (3) step(0, 2, 0, 0, 1, 0);
    repeat (5) step(0, 2, 1, 0, 1, 0);
    step(0, 2, 1, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0);
    repeat (6) step(0, 2, 0, 0, 1, 0);
    // Restart while running, clear beats start, start ignores its tick.
    step(1, 5, 0, 0, 0, 0);
    repeat (3) step(0, 5, 0, 0, 1, 0);
    step(1, 9, 0, 0, 1, 0);
    step(0, 9, 0, 0, 1, 0);
    step(1, 6, 0, 1, 1, 0);
    step(1, 15, 0, 0, 1, 0);
    step(0, 15, 0, 0, 0, 0);
    // Auto-reload (only meaningful when the feature is built in).
    step(1, 2, 0, 0, 0, ar_en);
    repeat (17) step(0, 2, 0, 0, 1, ar_en);
    repeat (9) step(0, 2, 0, 0, 1, 0);
    // Reset while counting.
    step(1, 12, 0, 0, 0, 0);
    repeat (4) step(0, 12, 0, 0, 1, 0);
    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      bit st, pa, cl, tk, ar;
      int v;
      if ($urandom_range(499) == 0) begin
        mid_reset();
      end else begin
        st = ($urandom_range(99) < 3);
        cl = ($urandom_range(99) < 1);
        pa = ($urandom_range(99) < 12);
        tk = ($urandom_range(99) < 60);
        ar = ar_en && ($urandom_range(99) < 50);
        v  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(15));
        step(st, v, pa, cl, tk, ar);
      end
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending predictions, required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
